// File: rtl/stream_fifo_rr_arbiter_if.sv
// ============================================================================
// Module   : stream_fifo_rr_arbiter_if
// Brief    : Producer-side and FIFO-side stream signals of the round-robin
//            FIFO arbiter, bundled for connection as one port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stream_fifo_rr_arbiter_if #(
  parameter int N_IN    = 2,
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 6
);
  logic [N_IN*WIDTH-1:0] in_V_V_TDATA;
  logic [N_IN-1:0]       in_V_V_TVALID;
  logic [N_IN-1:0]       in_V_V_TREADY;
  logic [WIDTH-1:0]      out_V_V_TDATA;
  logic                  out_V_V_TVALID;
  logic                  out_V_V_TREADY;
  logic [COUNT_W-1:0]    fifo_count;

  // Arbiter side
  modport master (
    input  in_V_V_TDATA,
    input  in_V_V_TVALID,
    output in_V_V_TREADY,
    output out_V_V_TDATA,
    output out_V_V_TVALID,
    input  out_V_V_TREADY,
    input  fifo_count
  );

  // Producers plus downstream FIFO side
  modport slave (
    output in_V_V_TDATA,
    output in_V_V_TVALID,
    input  in_V_V_TREADY,
    input  out_V_V_TDATA,
    input  out_V_V_TVALID,
    output out_V_V_TREADY,
    output fifo_count
  );
endinterface

`default_nettype wire

// File: rtl/stream_fifo_rr_arbiter.sv
// ============================================================================
// Module   : stream_fifo_rr_arbiter
// Brief    : Round-robin arbiter sharing one StreamingFIFO input between
//            N_IN AXI-Stream producers, granting bursts only when the FIFO
//            has room for a full burst.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_fifo_rr_arbiter #(
  parameter int N_IN       = 2,
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int COUNT_W    = 6,
  parameter int BURST      = 4,
  parameter int IDLE_REL   = 2
) (
  input  wire logic              ap_clk,
  input  wire logic              ap_rst_n,
  stream_fifo_rr_arbiter_if.master bus,
  output logic [N_IN-1:0]        grant,
  output logic                   busy
);

  localparam int c_ptr_w  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int c_beat_w = $clog2(BURST + 1);
  localparam int c_idle_w = $clog2(IDLE_REL + 1);

  localparam logic [COUNT_W:0]   c_depth     = (COUNT_W+1)'(FIFO_DEPTH);
  localparam logic [COUNT_W:0]   c_burst     = (COUNT_W+1)'(BURST);
  localparam logic [c_beat_w-1:0] c_beat_last = c_beat_w'(BURST - 1);
  localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(IDLE_REL - 1);
  localparam logic [N_IN-1:0]    c_one       = N_IN'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_max   = c_ptr_w'(N_IN - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_ptr_w-1:0]  r_ptr;
  logic [c_ptr_w-1:0]  r_sel;
  logic [N_IN-1:0]     r_grant;
  logic                r_busy;
  logic [c_beat_w-1:0] r_beat_cnt;
  logic [c_idle_w-1:0] r_idle_cnt;

  logic [COUNT_W:0]    w_count_ext;
  logic [COUNT_W:0]    w_free;
  logic                w_room;
  logic [c_ptr_w-1:0]  w_pick;
  logic                w_any;
  int                  w_idx;
  logic                w_xfer;
  logic                w_burst_done;
  logic                w_idle_done;
  logic [c_ptr_w-1:0]  w_next_ptr;

  // An over-range count (corrupt or transient) must never look like free space.
  assign w_count_ext = {1'b0, bus.fifo_count};
  assign w_free      = (w_count_ext > c_depth) ? '0 : (c_depth - w_count_ext);
  assign w_room      = (w_free >= c_burst);

  // Scan from the highest offset down so the lowest offset past ptr wins.
  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    w_idx  = 0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      w_idx = (int'(r_ptr) + k) % N_IN;
      if (bus.in_V_V_TVALID[w_idx]) begin
        w_pick = c_ptr_w'(w_idx);
        w_any  = 1'b1;
      end
    end
  end

  // r_grant is zero outside GRANT, which gates the whole datapath.
  assign bus.out_V_V_TDATA  = bus.in_V_V_TDATA[int'(r_sel)*WIDTH +: WIDTH];
  assign bus.out_V_V_TVALID = |(bus.in_V_V_TVALID & r_grant);
  assign bus.in_V_V_TREADY  = r_grant & {N_IN{bus.out_V_V_TREADY}};

  assign w_xfer       = bus.out_V_V_TVALID & bus.out_V_V_TREADY;
  assign w_burst_done = w_xfer && (r_beat_cnt == c_beat_last);
  assign w_idle_done  = !w_xfer && (r_idle_cnt == c_idle_last);
  assign w_next_ptr   = (r_sel == c_ptr_max) ? '0 : (r_sel + c_ptr_w'(1));

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_sel      <= '0;
      r_grant    <= '0;
      r_busy     <= 1'b0;
      r_beat_cnt <= '0;
      r_idle_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any && w_room) begin
            r_state <= ST_GRANT;
            r_sel   <= w_pick;
            r_grant <= c_one << w_pick;
            r_busy  <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (w_burst_done || w_idle_done) begin
            r_state    <= ST_SETTLE;
            r_grant    <= '0;
            r_ptr      <= w_next_ptr;
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
          end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + c_beat_w'(1);
            r_idle_cnt <= '0;
          end else begin
            r_idle_cnt <= r_idle_cnt + c_idle_w'(1);
          end
        end
        // One dead cycle lets fifo_count catch up with the finished burst.
        ST_SETTLE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign busy  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_stream_fifo_rr_arbiter.sv
// ============================================================================
// Module   : tb_stream_fifo_rr_arbiter
// Brief    : Self-checking bench for stream_fifo_rr_arbiter against a
//            transaction-level reference model, with directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_fifo_rr_arbiter;

  localparam int N0       = 2;
  localparam int N1       = 4;
  localparam int W        = 8;
  localparam int DEPTH    = 32;
  localparam int CW       = 6;
  localparam int BURST    = 4;
  localparam int IDLE_REL = 2;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  stream_fifo_rr_arbiter_if #(.N_IN(N0), .WIDTH(W), .COUNT_W(CW)) bus0 ();
  stream_fifo_rr_arbiter_if #(.N_IN(N1), .WIDTH(W), .COUNT_W(CW)) bus1 ();

  logic [N0-1:0] grant0;
  logic          busy0;
  logic [N1-1:0] grant1;
  logic          busy1;

  stream_fifo_rr_arbiter #(
    .N_IN(N0), .WIDTH(W), .FIFO_DEPTH(DEPTH), .COUNT_W(CW),
    .BURST(BURST), .IDLE_REL(IDLE_REL)
  ) dut0 (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus0),
    .grant    (grant0),
    .busy     (busy0)
  );

  stream_fifo_rr_arbiter #(
    .N_IN(N1), .WIDTH(W), .FIFO_DEPTH(DEPTH), .COUNT_W(CW),
    .BURST(BURST), .IDLE_REL(IDLE_REL)
  ) dut1 (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus1),
    .grant    (grant1),
    .busy     (busy1)
  );

  // Stimulus
  logic [N0-1:0] v0;
  logic [W-1:0]  d0 [N0];
  logic          rdy0;
  logic [CW-1:0] cnt0;
  logic [N1-1:0] v1;
  logic          rdy1;
  int            seq [N0];

  assign bus0.in_V_V_TDATA  = {d0[1], d0[0]};
  assign bus0.in_V_V_TVALID = v0;
  assign bus0.out_V_V_TREADY = rdy0;
  assign bus0.fifo_count    = cnt0;
  assign bus1.in_V_V_TDATA  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  assign bus1.in_V_V_TVALID = v1;
  assign bus1.out_V_V_TREADY = rdy1;
  assign bus1.fifo_count    = '0;

  // Reference model: owner of the current grant (-1 none), pointer, counters
  int m_owner, m_ptr, m_beats, m_quiet;
  bit m_settle;

  // Observations of the DUT for scenario checks
  logic [N0-1:0] prev_g0;
  logic [N1-1:0] prev_g1;
  int obs_owner[$], obs_cyc[$], obs_beats[$], obs_len[$], obs1_owner[$];
  int cur_beats, cur_len, cyc;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  function automatic logic [W-1:0] mk_data(input int s, input int n);
    return W'(s * 128 + (n % 128));
  endfunction

  function automatic int oh_idx(input logic [7:0] oh);
    for (int i = 0; i < 8; i++) if (oh[i]) return i;
    return -1;
  endfunction

  task automatic model_clear();
    m_owner = -1; m_ptr = 0; m_beats = 0; m_quiet = 0; m_settle = 0;
    prev_g0 = '0; prev_g1 = '0;
    obs_owner.delete(); obs_cyc.delete(); obs_beats.delete(); obs_len.delete();
    obs1_owner.delete();
    cur_beats = 0; cur_len = 0;
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    v0 = '0; v1 = '0; rdy0 = 1'b0; rdy1 = 1'b0; cnt0 = '0;
    model_clear();
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
  endtask

  // One clock: check outputs at negedge, then advance the model past the posedge.
  task automatic step();
    logic [N0-1:0] eg, er;
    logic ev, xfer;
    int free;
    @(negedge ap_clk);
    eg = '0; er = '0; ev = 1'b0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ev          = v0[m_owner];
      er[m_owner] = rdy0;
    end
    check_val("grant",  32'(grant0), 32'(eg));
    check_val("tvalid", 32'(bus0.out_V_V_TVALID), 32'(ev));
    check_val("tready", 32'(bus0.in_V_V_TREADY), 32'(er));
    check_val("busy",   32'(busy0), 32'((m_owner >= 0) || m_settle));
    if (m_owner >= 0) check_val("tdata", 32'(bus0.out_V_V_TDATA), 32'(d0[m_owner]));

    if (grant0 != 0 && prev_g0 == 0) begin
      obs_owner.push_back(oh_idx(8'(grant0)));
      obs_cyc.push_back(cyc);
      cur_beats = 0; cur_len = 0;
    end
    if (grant0 != 0) begin
      cur_len++;
      if (bus0.out_V_V_TVALID && rdy0) cur_beats++;
    end
    if (grant0 == 0 && prev_g0 != 0) begin
      obs_beats.push_back(cur_beats);
      obs_len.push_back(cur_len);
    end
    prev_g0 = grant0;

    if (v1 != 0) begin
      check_val("ready1_unrequested", 32'(bus1.in_V_V_TREADY & 4'b0101), 32'(0));
      if (grant1 != 0)
        check_val("tdata1", 32'(bus1.out_V_V_TDATA), 32'(8'hA0 + oh_idx(8'(grant1))));
    end
    if (grant1 != 0 && prev_g1 == 0) obs1_owner.push_back(oh_idx(8'(grant1)));
    prev_g1 = grant1;

    xfer = (m_owner >= 0) && v0[m_owner] && rdy0;
    free = (int'(cnt0) > DEPTH) ? 0 : DEPTH - int'(cnt0);
    @(posedge ap_clk);
    #1;
    cyc++;

    if (m_owner >= 0) begin
      if (xfer) begin
        m_beats++; m_quiet = 0;
        seq[m_owner]++;
        d0[m_owner] = mk_data(m_owner, seq[m_owner]);
      end else begin
        m_quiet++;
      end
      if (m_beats == BURST || m_quiet == IDLE_REL) begin
        m_ptr = (m_owner + 1) % N0;
        m_owner = -1; m_settle = 1; m_beats = 0; m_quiet = 0;
      end
    end else if (m_settle) begin
      m_settle = 0;
    end else if (v0 != 0 && free >= BURST) begin
      for (int k = 0; k < N0; k++) begin
        if (m_owner < 0 && v0[(m_ptr + k) % N0]) m_owner = (m_ptr + k) % N0;
      end
    end
  endtask

  initial begin
    int c2, s_start;
    cyc = 0;
    for (int i = 0; i < N0; i++) begin seq[i] = 0; d0[i] = mk_data(i, 0); end
    do_reset();

    // Reset state
    check_val("rst_grant0", 32'(grant0), 32'(0));
    check_val("rst_busy0",  32'(busy0), 32'(0));
    check_val("rst_tvalid0", 32'(bus0.out_V_V_TVALID), 32'(0));
    check_val("rst_tready0", 32'(bus0.in_V_V_TREADY), 32'(0));

    // Both streams saturating: alternating grants of 4 beats every 6 cycles
    v0 = 2'b11; rdy0 = 1'b1; cnt0 = '0;
    repeat (24) step();
    check_val("t1_ngrants", 32'(obs_owner.size() >= 4), 32'(1));
    if (obs_owner.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        check_val("t1_owner", 32'(obs_owner[k]), 32'(k % 2));
        check_val("t1_period", 32'(obs_cyc[k] - obs_cyc[0]), 32'(6 * k));
      end
    end
    if (obs_beats.size() >= 1) check_val("t1_beats", 32'(obs_beats[0]), 32'(BURST));

    // Too little room: no grant until count drops to 28
    do_reset();
    cnt0 = 6'd29; v0 = 2'b01; rdy0 = 1'b1;
    repeat (5) step();
    check_val("t2_no_grant", 32'(obs_owner.size()), 32'(0));
    cnt0 = 6'd28; c2 = cyc;
    repeat (2) step();
    check_val("t2_grant_now", 32'(obs_owner.size()), 32'(1));
    if (obs_owner.size() >= 1) check_val("t2_grant_cycle", 32'(obs_cyc[0]), 32'(c2 + 1));

    // Stream 1 stops after two beats: early release, then pointer at 0
    do_reset();
    v0 = 2'b10; rdy0 = 1'b1; cnt0 = '0; s_start = seq[1];
    for (int k = 0; k < 8; k++) begin
      if (seq[1] - s_start >= 2) v0 = 2'b00;
      step();
    end
    v0 = 2'b11;
    repeat (3) step();
    check_val("t3_nobs", 32'(obs_owner.size() >= 2 && obs_beats.size() >= 1), 32'(1));
    if (obs_owner.size() >= 2 && obs_beats.size() >= 1) begin
      check_val("t3_owner", 32'(obs_owner[0]), 32'(1));
      check_val("t3_beats", 32'(obs_beats[0]), 32'(2));
      check_val("t3_len",   32'(obs_len[0]), 32'(4));
      check_val("t3_next",  32'(obs_owner[1]), 32'(0));
    end

    // Back-pressure toggling during a burst
    do_reset();
    v0 = 2'b01; cnt0 = '0;
    for (int k = 0; k < 14; k++) begin
      rdy0 = k[0];
      step();
    end
    if (obs_beats.size() >= 1) begin
      check_val("t4_beats", 32'(obs_beats[0]), 32'(BURST));
      check_val("t4_len",   32'(obs_len[0]), 32'(7));
    end else begin
      check_val("t4_nbursts", 32'(obs_beats.size()), 32'(1));
    end

    // Asynchronous reset mid-burst, pointer restarts at 0
    do_reset();
    v0 = 2'b01; rdy0 = 1'b1; cnt0 = '0;
    repeat (9) step();
    check_val("t5_pre_grant", 32'(grant0), 32'(1));
    ap_rst_n = 1'b0;
    #1;
    check_val("t5_grant",  32'(grant0), 32'(0));
    check_val("t5_tvalid", 32'(bus0.out_V_V_TVALID), 32'(0));
    check_val("t5_tready", 32'(bus0.in_V_V_TREADY), 32'(0));
    model_clear();
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    v0 = 2'b11;
    repeat (3) step();
    check_val("t5_ngrants", 32'(obs_owner.size()), 32'(1));
    if (obs_owner.size() >= 1) check_val("t5_restart", 32'(obs_owner[0]), 32'(0));

    // Four producers, only 1 and 3 requesting
    do_reset();
    v1 = 4'b1010; rdy1 = 1'b1;
    repeat (30) step();
    check_val("t6_ngrants", 32'(obs1_owner.size() >= 4), 32'(1));
    if (obs1_owner.size() >= 4)
      for (int k = 0; k < 4; k++) check_val("t6_owner", 32'(obs1_owner[k]), 32'((k % 2) ? 3 : 1));
    v1 = '0;

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 800; k++) begin
      v0   = N0'($urandom_range(0, 3));
      rdy0 = ($urandom_range(0, 3) != 0);
      cnt0 = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(29, 63)) : CW'($urandom_range(0, 31));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
